bp_cfg_boot_sequencer: RTL

- Boot-time configuration sequencer for the core-complex mesh.
- After `start_i`, walks every core tile in row-major order over a single valid/ready config-write link, writing four registers per core in this order:
  - freeze = 1
  - core_id
  - cord
  - cce_mode
- After every core is configured, it unfreezes all cores in the same order, then reports done.
- Sits between the top-level boot/reset logic and the config-link fanout to the cc tiles.

---
 rtl/bp_cfg_boot_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/bp_cfg_boot_sequencer.sv
// Boot config sequencer: writes freeze/core_id/cord/cce_mode per tile in row-major order, then unfreezes all; first valid one cycle after start.
// Registered outputs; one write per cycle when ready is high, payload held stable while cfg_ready_i is low.
module bp_cfg_boot_sequencer #(
  parameter int cc_x_dim_p       = 2,
  parameter int cc_y_dim_p       = 1,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  input  logic                        cce_mode_i,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [3:0]                  cfg_dst_x_o,
  output logic [3:0]                  cfg_dst_y_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  output logic                        busy_o,
  output logic                        done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FREEZE, S_CORE_ID, S_CORD, S_CCE_MODE, S_UNFREEZE, S_DONE
  } state_e;

  localparam logic [3:0] x_last = 4'(cc_x_dim_p - 1);
  localparam logic [3:0] y_last = 4'(cc_y_dim_p - 1);

  localparam logic [cfg_addr_width_p-1:0] addr_freeze   = cfg_addr_width_p'(1);
  localparam logic [cfg_addr_width_p-1:0] addr_core_id  = cfg_addr_width_p'(2);
  localparam logic [cfg_addr_width_p-1:0] addr_cord     = cfg_addr_width_p'(3);
  localparam logic [cfg_addr_width_p-1:0] addr_cce_mode = cfg_addr_width_p'(4);

  state_e state_r, state_n;
  logic [3:0] x_r, x_n, y_r, y_n;
  logic [3:0] x_adv, y_adv;
  logic       mode_r, mode_n;
  logic       xfer, last_tile;

  logic                        v_n, busy_n, done_n;
  logic [cfg_addr_width_p-1:0] addr_n;
  logic [cfg_data_width_p-1:0] data_n;
  logic [7:0]                  core_id;

  assign xfer      = cfg_v_o & cfg_ready_i;
  assign last_tile = (x_r == x_last) && (y_r == y_last);

  always_comb begin
    x_adv = x_r + 4'd1;
    y_adv = y_r;
    if (x_r == x_last) begin
      x_adv = 4'd0;
      y_adv = y_r + 4'd1;
    end
  end

  // State register; outputs are registered from the next-state values so they align with state_r.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= S_IDLE;
      x_r         <= 4'd0;
      y_r         <= 4'd0;
      mode_r      <= 1'b0;
      cfg_v_o     <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      cfg_dst_x_o <= 4'd0;
      cfg_dst_y_o <= 4'd0;
      cfg_addr_o  <= '0;
      cfg_data_o  <= '0;
    end else begin
      state_r     <= state_n;
      x_r         <= x_n;
      y_r         <= y_n;
      mode_r      <= mode_n;
      cfg_v_o     <= v_n;
      busy_o      <= busy_n;
      done_o      <= done_n;
      cfg_dst_x_o <= x_n;
      cfg_dst_y_o <= y_n;
      cfg_addr_o  <= addr_n;
      cfg_data_o  <= data_n;
    end
  end

  always_comb begin
    state_n = state_r;
    x_n     = x_r;
    y_n     = y_r;
    mode_n  = mode_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_n = S_FREEZE;
          mode_n  = cce_mode_i;
          x_n     = 4'd0;
          y_n     = 4'd0;
        end
      end
      S_FREEZE:  if (xfer) state_n = S_CORE_ID;
      S_CORE_ID: if (xfer) state_n = S_CORD;
      S_CORD:    if (xfer) state_n = S_CCE_MODE;
      S_CCE_MODE: begin
        if (xfer) begin
          if (last_tile) begin
            state_n = S_UNFREEZE;
            x_n     = 4'd0;
            y_n     = 4'd0;
          end else begin
            state_n = S_FREEZE;
            x_n     = x_adv;
            y_n     = y_adv;
          end
        end
      end
      S_UNFREEZE: begin
        if (xfer) begin
          if (last_tile) begin
            state_n = S_DONE;
          end else begin
            x_n = x_adv;
            y_n = y_adv;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    v_n     = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    addr_n  = '0;
    data_n  = '0;
    core_id = 8'(y_n) * 8'(cc_x_dim_p) + 8'(x_n);
    case (state_n)
      S_FREEZE: begin
        v_n    = 1'b1;
        busy_n = 1'b1;
        addr_n = addr_freeze;
        data_n = cfg_data_width_p'(1);
      end
      S_CORE_ID: begin
        v_n    = 1'b1;
        busy_n = 1'b1;
        addr_n = addr_core_id;
        data_n = cfg_data_width_p'(core_id);
      end
      S_CORD: begin
        v_n    = 1'b1;
        busy_n = 1'b1;
        addr_n = addr_cord;
        data_n = cfg_data_width_p'({4'd0, y_n, 4'd0, x_n});
      end
      S_CCE_MODE: begin
        v_n    = 1'b1;
        busy_n = 1'b1;
        addr_n = addr_cce_mode;
        data_n = cfg_data_width_p'(mode_n);
      end
      S_UNFREEZE: begin
        v_n    = 1'b1;
        busy_n = 1'b1;
        addr_n = addr_freeze;
      end
      S_DONE:  done_n = 1'b1;
      default: ;
    endcase
  end

  a_payload_stable: assert property (@(posedge clk_i) disable iff (reset_i)
    (cfg_v_o && !cfg_ready_i) |=> (cfg_v_o && $stable(cfg_addr_o) && $stable(cfg_data_o)
                                   && $stable(cfg_dst_x_o) && $stable(cfg_dst_y_o)));

  a_dims_legal: assert property (@(posedge clk_i)
    (cc_x_dim_p >= 1) && (cc_x_dim_p <= 16) && (cc_y_dim_p >= 1) && (cc_y_dim_p <= 16));

endmodule
